// File: rtl/pending_priority_encoder.sv
// rtl/pending_priority_encoder.sv - serialises a multi-hot request vector into a lowest-first binary index stream
module pending_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         out_last,
    output logic         zero_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [N-1:0] pending, pending_nxt;
    logic         zero_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            zero_err <= zero_err_nxt;
        end
    end

    // Descending scan so the lowest set bit wins; pending==0 yields index 0.
    always_comb begin
        y = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) y = W'(i);
        end
    end

    assign out_last  = (pending != '0) && ((pending & (pending - ONE)) == '0);
    assign out_valid = (state == BUSY);
    assign in_ready  = (state == IDLE);

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        zero_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (d != '0) begin
                        pending_nxt = d;
                        state_nxt   = BUSY;
                    end else begin
                        zero_err_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pending_nxt = pending & ~(ONE << y);
                    if (pending_nxt == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// tb/tb_pending_priority_encoder.sv - self-checking bench for pending_priority_encoder
module tb_pending_priority_encoder;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, zero_err;
    logic [3:0] d;
    logic [1:0] y;

    int vectors = 0;
    int fails   = 0;
    int q[$];
    int hs[$];
    bit zexp = 1'b0;

    pending_priority_encoder #(.N(4), .W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_last(out_last),
        .zero_err(zero_err)
    );

    always #5 clk = ~clk;

    // Reference: a queue of indices still owed for the vector in flight.
    function automatic logic [5:0] exp_vec();
        logic [1:0] ey;
        ey = (q.size() > 0) ? 2'(q[0]) : 2'd0;
        return {q.size() == 0, q.size() > 0, ey, q.size() == 1, zexp};
    endfunction

    function automatic logic [5:0] obs();
        return {in_ready, out_valid, y, out_last, zero_err};
    endfunction

    task automatic tick(input logic r, input logic iv, input logic [3:0] dd, input logic ordy);
        rst = r; in_valid = iv; d = dd; out_ready = ordy;
        if (!r && out_valid && ordy) hs.push_back(int'(y));
        if (r) begin
            q.delete();
            zexp = 1'b0;
        end else if (q.size() == 0) begin
            zexp = iv && (dd == 4'b0000);
            if (iv) for (int i = 0; i < 4; i++) if (dd[i]) q.push_back(i);
        end else begin
            zexp = 1'b0;
            if (ordy) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 4'b1111, 1);
        vectors++;
        if (obs() !== 6'b100000) begin
            fails++; $display("FAIL reset: got %b want %b", obs(), 6'b100000);
        end
        tick(0, 0, 4'b0000, 0);
        vectors++;
        if (obs() !== exp_vec()) begin
            fails++; $display("FAIL reset_idle: got %b want %b", obs(), exp_vec());
        end
    endtask

    task automatic test_single();
        tick(0, 1, 4'b0100, 0);
        vectors++;
        if (obs() !== 6'b011010 || obs() !== exp_vec()) begin
            fails++; $display("FAIL single_first: got %b want %b", obs(), 6'b011010);
        end
        tick(0, 0, 4'b0000, 1);
        vectors++;
        if (obs() !== 6'b100000) begin
            fails++; $display("FAIL single_done: got %b want %b", obs(), 6'b100000);
        end
    endtask

    task automatic test_back_to_back();
        int exp_hs[$] = '{0, 1, 3};
        bit bad;
        hs.delete();
        tick(0, 1, 4'b1011, 1);
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL b2b cyc%0d: got %b want %b", c, obs(), exp_vec());
            end
            tick(0, 0, 4'b0000, 1);
        end
        bad = (hs.size() != exp_hs.size());
        for (int i = 0; i < hs.size(); i++) if (!bad && hs[i] != exp_hs[i]) bad = 1'b1;
        vectors++;
        if (bad) begin
            fails++; $display("FAIL b2b_seq: got %0d indices %p want %p", hs.size(), hs, exp_hs);
        end
    endtask

    task automatic test_stall();
        int exp_hs[$] = '{0, 1, 2, 3};
        logic rdy[6] = '{1, 0, 0, 1, 1, 1};
        bit bad;
        hs.delete();
        tick(0, 1, 4'b1111, 0);
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL stall cyc%0d: got %b want %b", c, obs(), exp_vec());
            end
            tick(0, 0, 4'b0000, rdy[c]);
        end
        vectors++;
        if (obs() !== 6'b100000) begin
            fails++; $display("FAIL stall_done: got %b want %b", obs(), 6'b100000);
        end
        bad = (hs.size() != exp_hs.size());
        for (int i = 0; i < hs.size(); i++) if (!bad && hs[i] != exp_hs[i]) bad = 1'b1;
        vectors++;
        if (bad) begin
            fails++; $display("FAIL stall_seq: got %0d handshakes %p want %p", hs.size(), hs, exp_hs);
        end
    endtask

    task automatic test_zero();
        tick(0, 1, 4'b0000, 1);
        vectors++;
        if (obs() !== 6'b100001) begin
            fails++; $display("FAIL zero_pulse: got %b want %b", obs(), 6'b100001);
        end
        tick(0, 0, 4'b0000, 1);
        vectors++;
        if (obs() !== 6'b100000) begin
            fails++; $display("FAIL zero_clear: got %b want %b", obs(), 6'b100000);
        end
    endtask

    task automatic test_reset_busy();
        tick(0, 1, 4'b0110, 0);
        tick(0, 0, 4'b0000, 1);
        vectors++;
        if (obs() !== 6'b011010) begin
            fails++; $display("FAIL rbusy_pre: got %b want %b", obs(), 6'b011010);
        end
        tick(1, 0, 4'b0000, 0);
        vectors++;
        if (obs() !== 6'b100000) begin
            fails++; $display("FAIL rbusy_reset: got %b want %b", obs(), 6'b100000);
        end
        tick(0, 1, 4'b1000, 0);
        vectors++;
        if (obs() !== 6'b011110) begin
            fails++; $display("FAIL rbusy_new: got %b want %b", obs(), 6'b011110);
        end
        tick(0, 0, 4'b0000, 1);
    endtask

    task automatic test_ignore_busy();
        int exp_hs[$] = '{0, 1};
        bit bad;
        hs.delete();
        tick(0, 1, 4'b0011, 0);
        tick(0, 1, 4'b1100, 1);
        tick(0, 1, 4'b1100, 1);
        vectors++;
        if (obs() !== 6'b100000) begin
            fails++; $display("FAIL ignore_done: got %b want %b", obs(), 6'b100000);
        end
        tick(0, 0, 4'b0000, 0);
        bad = (hs.size() != exp_hs.size());
        for (int i = 0; i < hs.size(); i++) if (!bad && hs[i] != exp_hs[i]) bad = 1'b1;
        vectors++;
        if (bad) begin
            fails++; $display("FAIL ignore_seq: got %0d indices %p want %p", hs.size(), hs, exp_hs);
        end
    endtask

    task automatic test_random();
        logic       r, iv, ordy;
        logic [3:0] dd;
        for (int c = 0; c < 500; c++) begin
            r    = ($urandom_range(0, 59) == 0);
            iv   = $urandom_range(0, 1);
            dd   = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            tick(r, iv, dd, ordy);
            vectors++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL random cyc%0d: got %b want %b", c, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_zero();
        test_reset_busy();
        test_ignore_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
